// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, round constants, initial hash values and
// the small-sigma helpers used by the message schedule.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int ROUNDS      = 64;
    localparam int BLOCK_WORDS = 16;

    localparam logic [5:0] LAST_IDX = 6'd63;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam word_t SHA256_K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t SHA256_H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/msg_sched_expand.sv
// Combinational next-schedule-word adder, kept separate so it can be retimed on its own.
module msg_sched_expand
    import sha256_pkg::*;
(
    input  logic [31:0] w_tm2,
    input  logic [31:0] w_tm7,
    input  logic [31:0] w_tm15,
    input  logic [31:0] w_tm16,
    output logic [31:0] w_new
);

    // Carries out of bit 31 are dropped: the sum is modulo 2^32.
    assign w_new = ssig1(w_tm2) + w_tm7 + ssig0(w_tm15) + w_tm16;

endmodule

// File: rtl/msg_schedule_gen.sv
// SHA-256 message schedule: streams W[0..63] for one 512-bit block per handshake.
// Optional k_t round-constant output is enabled with SHA256_SCHED_KT_EN.
module msg_schedule_gen
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_t,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
`ifdef SHA256_SCHED_KT_EN
    ,
    output logic [31:0]  k_t
`endif
);

    logic [0:0] state_q, state_d;
    logic [5:0] idx_q, idx_d;
    word_t      win_q [BLOCK_WORDS];
    word_t      win_d [BLOCK_WORDS];
    word_t      w_next;
    logic       run;
    logic       beat;
    logic       accept;

    msg_sched_expand u_expand (
        .w_tm2  (win_q[14]),
        .w_tm7  (win_q[9]),
        .w_tm15 (win_q[1]),
        .w_tm16 (win_q[0]),
        .w_new  (w_next)
    );

    assign run     = (state_q == ST_RUN);
    assign w_valid = run;
    assign busy    = run;
    assign w_t     = win_q[0];
    assign w_idx   = idx_q;
    assign w_last  = run && (idx_q == LAST_IDX);
    assign beat    = run && w_ready;

    // The next block may be taken in the same cycle the final word leaves.
    assign blk_ready = !run || (w_last && w_ready);
    assign accept    = blk_valid && blk_ready;

`ifdef SHA256_SCHED_KT_EN
    assign k_t = SHA256_K[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            win_d[i] = win_q[i];
        end

        if (accept) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win_d[i] = blk_data[(BLOCK_WORDS - 1 - i) * 32 +: 32];
            end
            idx_d   = 6'd0;
            state_d = ST_RUN;
        end else if (beat) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
            end else begin
                for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[BLOCK_WORDS - 1] = w_next;
                idx_d = idx_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_msg_schedule_gen.sv
// Directed bench for msg_schedule_gen with a scoreboard of expected schedule words.
// Define SHA256_SCHED_KT_EN for both RTL and bench to cover the k_t output.
module tb_msg_schedule_gen;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_t;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;
`ifdef SHA256_SCHED_KT_EN
    logic [31:0]  k_t;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] cap [64];
    int hs_cnt = 0;
    int run_len = 0;
    int max_run = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_w = '0;
    logic [5:0] prev_i = '0;

    logic [511:0] abc_blk;

    msg_schedule_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_t       (w_t),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
`ifdef SHA256_SCHED_KT_EN
        ,
        .k_t       (k_t)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic push_block(input logic [511:0] b);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) begin
            e.idx = 6'(i);
            e.w   = w[i];
            sb.push_back(e);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_w_t", w_t, prev_w);
                check_val("stall_w_idx", {26'd0, w_idx}, {26'd0, prev_i});
            end
            if (w_valid === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (w_valid === 1'b1 && w_ready === 1'b1) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_beat: observed idx %0d expected no beat", w_idx);
                end else begin
                    e = sb.pop_front();
                    check_val("w_t", w_t, e.w);
                    check_val("w_idx", {26'd0, w_idx}, {26'd0, e.idx});
                    check_val("w_last", {31'd0, w_last}, {31'd0, (e.idx == 6'd63)});
                    cap[e.idx] = w_t;
`ifdef SHA256_SCHED_KT_EN
                    if (e.idx == 6'd0)  check_val("k_t_0", k_t, 32'h428A2F98);
                    if (e.idx == 6'd63) check_val("k_t_63", k_t, 32'hC67178F2);
`endif
                end
            end
            prev_stall = (w_valid === 1'b1) && (w_ready !== 1'b1);
            prev_w     = w_t;
            prev_i     = w_idx;
            if (blk_valid === 1'b1 && blk_ready === 1'b1) push_block(blk_data);
        end
    end

    task automatic send_block(input logic [511:0] b, output logic [5:0] acc_idx);
        int n;
        blk_data  = b;
        blk_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (blk_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc_idx = w_idx;
        checks++;
        assert (n < 300) else begin
            errors++;
            $error("FAIL accept_timeout: observed %0d cycles expected < 300", n);
        end
        @(posedge clk);
        #1 blk_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || w_valid === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d words left expected 0", sb.size());
        end
    endtask

    task automatic wait_idx(input logic [5:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (!(w_valid === 1'b1 && w_idx === target) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 300) else begin
            errors++;
            $error("FAIL idx_timeout: observed idx %0d expected %0d", w_idx, target);
        end
    endtask

    initial begin
        logic [5:0]   acc;
        logic [511:0] rnd_blk;
        int n;

        abc_blk   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        rst_n     = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_w_valid", {31'd0, w_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_w_last", {31'd0, w_last}, 32'd0);
        check_val("rst_w_idx", {26'd0, w_idx}, 32'd0);
        check_val("rst_w_t", w_t, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_blk_ready", {31'd0, blk_ready}, 32'd1);

        // Scenario 1: "abc" at full throughput
        w_ready = 1'b1;
        send_block(abc_blk, acc);
        wait_done();
        check_val("abc_W0", cap[0], 32'h61626380);
        check_val("abc_W15", cap[15], 32'h00000018);
        check_val("abc_W16", cap[16], 32'h61626380);
        check_val("abc_W17", cap[17], 32'h000F0000);

        // Scenario 2: random consumer back-pressure
        @(posedge clk);
        #1 w_ready = 1'b0;
        hs_cnt = 0;
        send_block(abc_blk, acc);
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1 w_ready = 1'($urandom_range(0, 1));
            n++;
        end
        w_ready = 1'b1;
        wait_done();
        check_val("stall_handshakes", hs_cnt, 32'd64);

        // Scenario 3: back-to-back blocks with no bubble
        @(posedge clk);
        #1 max_run = 0;
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom;
        send_block(abc_blk, acc);
        send_block(rnd_blk, acc);
        check_val("b2b_accept_idx", {26'd0, acc}, 32'd63);
        wait_done();
        check_val("b2b_valid_run", max_run, 32'd128);

        // Scenario 4: block offered mid-run is refused
        send_block(abc_blk, acc);
        wait_idx(6'd10);
        @(posedge clk);
        for (int i = 0; i < 16; i++) blk_data[32*i +: 32] = $urandom;
        #1 blk_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("midrun_blk_ready", {31'd0, blk_ready}, 32'd0);
        end
        @(posedge clk);
        #1 blk_valid = 1'b0;
        wait_done();

        // Scenario 5: asynchronous reset in the middle of a block
        send_block(abc_blk, acc);
        wait_idx(6'd30);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_w_valid", {31'd0, w_valid}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_w_idx", {26'd0, w_idx}, 32'd0);
        check_val("arst_w_t", w_t, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("arst_blk_ready", {31'd0, blk_ready}, 32'd1);
        send_block(abc_blk, acc);
        wait_done();

        check_val("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
